cp0_regfile: RTL
================

Name: cp0_regfile

Overview:
- Coprocessor-0 register file directly downstream of the exception unit.
- Consumes the exception unit's commit strobes: wr_exp, exp_code, epc, badvaddr, badvaddr_we and clear_exl.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC, and serves MTC0/MFC0.
- Feeds epc_in, allow_int and interrupt_flag back to the exception unit. Includes the Count/Compare timer interrupt.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (1 or 2 supported).
- BEV_RESET, 1, reset and fixed value of Status.BEV.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mtc0_we  in  1  MTC0 write enable
- mtc0_addr  in  5  MTC0 register number (sel fixed 0)
- mtc0_wdata  in  32  MTC0 data
- mfc0_addr  in  5  MFC0 register number
- mfc0_rdata  out  32  MFC0 read data, combinational
- wr_exp  in  1  exception commit strobe
- exp_code  in  5  ExcCode for the committed exception
- exc_epc  in  32  faulting PC (already delay-slot adjusted)
- exc_bd  in  1  faulting instruction is in a delay slot
- badvaddr  in  32  faulting address
- badvaddr_we  in  1  BadVAddr update strobe
- clear_exl  in  1  ERET commit strobe
- hw_int  in  6  external interrupt lines, level-sensitive, already synchronised
- epc_in  out  32  current EPC
- allow_int  out  1  Status.IE & ~Status.EXL
- interrupt_flag  out  8  Cause.IP & Status.IM
- status_out  out  32  current Status
- cause_out  out  32  current Cause

Behaviour:
- One clock (clk). rst is synchronous, active-high. All state updates on posedge clk.
- Reset values:
  - Status = BEV_RESET<<22, so IE=0, EXL=0, IM=0.
  - Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0.
  - Divider phase = 0, timer interrupt TI = 0.
- Register map (address → register):
  - 8 BadVAddr: read-only to software.
  - 9 Count: RW.
  - 11 Compare: RW.
  - 12 Status: writable bits IM[15:8], EXL[1], IE[0]; BEV read-only; all other bits read 0.
  - 13 Cause: BD[31] and TI[30] read-only; IP[15:10] hardware; IP[9:8] software-writable; ExcCode[6:2] read-only; all other bits read 0.
  - 14 EPC: RW.
  - Any other address: reads 0, writes ignored.
- MFC0 reads are combinational from current register state. A same-cycle MTC0 to the same address is not forwarded; the old value is returned.
- Count:
  - Increments by 1 when the divider phase reaches COUNT_DIV-1; the phase then wraps to 0.
  - Wraps modulo 2^32 (0xFFFFFFFF → 0).
  - An MTC0 to Count loads mtc0_wdata and resets the phase to 0. No increment occurs that cycle.
- Timer:
  - TI is set the cycle after registered Count == Compare (compare on current register values, evaluated every cycle).
  - TI is cleared only by an MTC0 to Compare. Clear wins over a same-cycle match.
- Cause.IP (per cycle):
  - IP[15] = hw_int[5] | TI.
  - IP[14:10] = hw_int[4:0], sampled every cycle.
- Exception commit (wr_exp=1):
  - Cause.ExcCode ← exp_code.
  - If Status.EXL was 0: EPC ← exc_epc, Cause.BD ← exc_bd.
  - If Status.EXL was already 1: EPC and BD are unchanged.
  - Status.EXL ← 1.
  - If badvaddr_we: BadVAddr ← badvaddr.
- ERET (clear_exl=1, wr_exp=0): Status.EXL ← 0. Nothing else changes.
- Simultaneous events:
  - wr_exp has priority over clear_exl.
  - When wr_exp or clear_exl is high, the MTC0 in that cycle is discarded entirely, because its instruction is being flushed.
  - Timer and hw_int updates to IP and Count increments still occur in those cycles.
- Outputs:
  - allow_int, interrupt_flag, epc_in, status_out and cause_out are combinational from registered state only; no input-to-output path.
  - Consequently a flag becomes visible one cycle after the causing event.
- Reset asserted mid-operation overrides every concurrent strobe that cycle.

Test Plan:
- Reset, then read addresses 8/9/11/12/13/14/5 → values 0, 0, 0, 0x00400000, 0, 0, 0.
- Timer (COUNT_DIV=2):
  - MTC0 Compare=5, Count=0 → Count reaches 5 after 10 cycles; Cause bit30 and bit15 set the next cycle.
  - With Status=0x8001, allow_int=1 and interrupt_flag=0x80.
  - MTC0 Compare=5 again → TI clears.
- Exception commit:
  - wr_exp=1, exp_code=0x04, exc_epc=0xBFC00104, exc_bd=1, badvaddr_we=1, badvaddr=0x00000003.
  - Expect EPC=0xBFC00104, Cause=0x80000010, BadVAddr=3, EXL=1, allow_int=0.
- Nested exception while EXL=1 with exc_epc=0x100 → EPC stays 0xBFC00104; ExcCode updated.
- clear_exl=1 and MTC0 EPC=0x1234 in the same cycle → EXL=0; EPC unchanged (MTC0 dropped).
- Software interrupt: MTC0 Cause=0x300, Status=0x301 → interrupt_flag=0x03 and allow_int=1 next cycle. Count wrap: load 0xFFFFFFFF → reads 0 two cycles later.

Source files
------------

// File: rtl/cp0_regfile_if.sv
// CP0 register file bus: MTC0/MFC0 port, exception-unit commit strobes and
// the status/interrupt feedback returned to the exception unit.
interface cp0_regfile_if;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_rdata;

  logic        wr_exp;
  logic [4:0]  exp_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic [31:0] badvaddr;
  logic        badvaddr_we;
  logic        clear_exl;
  logic [5:0]  hw_int;

  logic [31:0] epc_in;
  logic        allow_int;
  logic [7:0]  interrupt_flag;
  logic [31:0] status_out;
  logic [31:0] cause_out;

  modport master (
    output mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
    output wr_exp, exp_code, exc_epc, exc_bd, badvaddr, badvaddr_we, clear_exl, hw_int,
    input  mfc0_rdata, epc_in, allow_int, interrupt_flag, status_out, cause_out
  );

  modport slave (
    input  mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
    input  wr_exp, exp_code, exc_epc, exc_bd, badvaddr, badvaddr_we, clear_exl, hw_int,
    output mfc0_rdata, epc_in, allow_int, interrupt_flag, status_out, cause_out
  );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: BadVAddr, Count/Compare timer, Status, Cause, EPC.
// Commits exception/ERET updates and feeds interrupt status back to the exception unit.
module cp0_regfile #(
  parameter int COUNT_DIV = 2,
  parameter bit BEV_RESET = 1'b1
) (
  input logic        clk,
  input logic        rst,
  cp0_regfile_if.slave cp0
);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;

  logic [31:0] badvaddr_r;
  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic [31:0] epc_r;
  logic [7:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic        bd_r;
  logic        ti_r;
  logic [5:0]  hw_ip_r;
  logic [1:0]  sw_ip_r;
  logic [4:0]  exc_code_r;
  logic        phase_r;

  logic        flush;
  logic        mtc0_ok;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic        count_tick;
  logic [7:0]  ip;
  logic [31:0] status_w;
  logic [31:0] cause_w;

  // An MTC0 sharing a cycle with an exception or ERET belongs to a flushed instruction.
  assign flush   = cp0.wr_exp | cp0.clear_exl;
  assign mtc0_ok = cp0.mtc0_we & ~flush;

  assign wr_count   = mtc0_ok & (cp0.mtc0_addr == A_COUNT);
  assign wr_compare = mtc0_ok & (cp0.mtc0_addr == A_COMPARE);
  assign wr_status  = mtc0_ok & (cp0.mtc0_addr == A_STATUS);
  assign wr_cause   = mtc0_ok & (cp0.mtc0_addr == A_CAUSE);
  assign wr_epc     = mtc0_ok & (cp0.mtc0_addr == A_EPC);

  assign count_tick = (COUNT_DIV == 1) ? 1'b1 : phase_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_r <= '0;
      count_r    <= '0;
      compare_r  <= '0;
      epc_r      <= '0;
      im_r       <= '0;
      exl_r      <= 1'b0;
      ie_r       <= 1'b0;
      bd_r       <= 1'b0;
      ti_r       <= 1'b0;
      hw_ip_r    <= '0;
      sw_ip_r    <= '0;
      exc_code_r <= '0;
      phase_r    <= 1'b0;
    end else begin
      if (wr_count) begin
        count_r <= cp0.mtc0_wdata;
        phase_r <= 1'b0;
      end else begin
        if (count_tick) count_r <= count_r + 32'd1;
        phase_r <= (COUNT_DIV == 1) ? 1'b0 : ~phase_r;
      end

      // Writing Compare acknowledges the timer and beats a coincident match.
      if (wr_compare) begin
        compare_r <= cp0.mtc0_wdata;
        ti_r      <= 1'b0;
      end else if (count_r == compare_r) begin
        ti_r      <= 1'b1;
      end

      hw_ip_r <= cp0.hw_int;

      if (wr_status) begin
        im_r  <= cp0.mtc0_wdata[15:8];
        exl_r <= cp0.mtc0_wdata[1];
        ie_r  <= cp0.mtc0_wdata[0];
      end
      if (wr_cause) sw_ip_r <= cp0.mtc0_wdata[9:8];
      if (wr_epc)   epc_r   <= cp0.mtc0_wdata;

      if (cp0.wr_exp) begin
        exc_code_r <= cp0.exp_code;
        // A nested exception keeps the original return point.
        if (!exl_r) begin
          epc_r <= cp0.exc_epc;
          bd_r  <= cp0.exc_bd;
        end
        exl_r <= 1'b1;
        if (cp0.badvaddr_we) badvaddr_r <= cp0.badvaddr;
      end else if (cp0.clear_exl) begin
        exl_r <= 1'b0;
      end
    end
  end

  assign ip = {hw_ip_r[5] | ti_r, hw_ip_r[4:0], sw_ip_r};

  assign status_w = {9'b0, BEV_RESET, 6'b0, im_r, 6'b0, exl_r, ie_r};
  assign cause_w  = {bd_r, ti_r, 14'b0, ip, 1'b0, exc_code_r, 2'b0};

  always_comb begin
    cp0.mfc0_rdata = '0;
    unique case (cp0.mfc0_addr)
      A_BADVADDR: cp0.mfc0_rdata = badvaddr_r;
      A_COUNT:    cp0.mfc0_rdata = count_r;
      A_COMPARE:  cp0.mfc0_rdata = compare_r;
      A_STATUS:   cp0.mfc0_rdata = status_w;
      A_CAUSE:    cp0.mfc0_rdata = cause_w;
      A_EPC:      cp0.mfc0_rdata = epc_r;
      default:    cp0.mfc0_rdata = '0;
    endcase
  end

  assign cp0.epc_in         = epc_r;
  assign cp0.allow_int      = ie_r & ~exl_r;
  assign cp0.interrupt_flag = ip & im_r;
  assign cp0.status_out     = status_w;
  assign cp0.cause_out      = cause_w;

endmodule
